// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/HI-LO stalls,
// and the busy sequencer for the multi-cycle multiply/divide unit.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeRegE,
    input  logic [4:0] writeRegM,
    input  logic [4:0] writeRegW,
    input  logic       Regfile_weE,
    input  logic       Regfile_weM,
    input  logic       Regfile_weW,
    input  logic       memToRegE,
    input  logic       memToRegM,
    input  logic       branchD,
    input  logic       pcSrcD,
    input  logic       mdStartD,
    input  logic       mdStartE,
    input  logic       mdOpE,
    input  logic       hiloReadD,
    output logic       stallF,
    output logic       stallD,
    output logic       flushD,
    output logic       flushE,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic       mdBusy,
    output logic       mdDone
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 2);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdState_t;

    mdState_t      state_r, stateNext_s;
    logic [CW-1:0] count_r, countNext_s, loadVal_s;
    logic          lwStall_s, brStall_s, mdStall_s, stall_s;

    assign loadVal_s = mdOpE ? DIV_LOAD : MUL_LOAD;

    // Mul/div state and busy-count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            count_r <= '0;
        end else begin
            state_r <= stateNext_s;
            count_r <= countNext_s;
        end
    end

    // Next state: count holds the BUSY cycles still to run, so a load of 0 goes straight to DONE.
    always_comb begin
        stateNext_s = state_r;
        countNext_s = count_r;
        case (state_r)
            IDLE, DONE: begin
                if (mdStartE) begin
                    stateNext_s = (loadVal_s == '0) ? DONE : BUSY;
                    countNext_s = loadVal_s;
                end else begin
                    stateNext_s = IDLE;
                    countNext_s = '0;
                end
            end
            BUSY: begin
                if (count_r <= CW'(1)) begin
                    stateNext_s = DONE;
                    countNext_s = '0;
                end else begin
                    countNext_s = count_r - CW'(1);
                end
            end
            default: begin
                stateNext_s = IDLE;
                countNext_s = '0;
            end
        endcase
    end

    // Stall sources; a DONE cycle without a new launch lets HI/LO users through.
    always_comb begin
        lwStall_s = memToRegE && (writeRegE != 5'd0) &&
                    ((rsD == writeRegE) || (rtD == writeRegE));
        brStall_s = branchD &&
                    ((Regfile_weE && (writeRegE != 5'd0) &&
                      ((writeRegE == rsD) || (writeRegE == rtD))) ||
                     (memToRegM && (writeRegM != 5'd0) &&
                      ((writeRegM == rsD) || (writeRegM == rtD))));
        mdStall_s = (hiloReadD || mdStartD) && ((state_r == BUSY) || mdStartE);
        stall_s   = rst && (lwStall_s || brStall_s || mdStall_s);
    end

    // Pipeline control and forwarding outputs, all held low while in reset.
    always_comb begin
        stallF    = stall_s;
        stallD    = stall_s;
        flushE    = stall_s;
        flushD    = rst && pcSrcD && !stall_s;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        forwardAD = rst && (rsD != 5'd0) && (rsD == writeRegM) && Regfile_weM;
        forwardBD = rst && (rtD != 5'd0) && (rtD == writeRegM) && Regfile_weM;
        if (!rst) begin
            forwardAE = 2'b00;
        end else if ((rsE != 5'd0) && (rsE == writeRegM) && Regfile_weM) begin
            forwardAE = 2'b10;
        end else if ((rsE != 5'd0) && (rsE == writeRegW) && Regfile_weW) begin
            forwardAE = 2'b01;
        end else begin
            forwardAE = 2'b00;
        end
        if (!rst) begin
            forwardBE = 2'b00;
        end else if ((rtE != 5'd0) && (rtE == writeRegM) && Regfile_weM) begin
            forwardBE = 2'b10;
        end else if ((rtE != 5'd0) && (rtE == writeRegW) && Regfile_weW) begin
            forwardBE = 2'b01;
        end else begin
            forwardBE = 2'b00;
        end
    end

    assign mdBusy = (state_r == BUSY) || (state_r == DONE);
    assign mdDone = (state_r == DONE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-age model of the mul/div unit.
module tb_hazard_ctrl;

    localparam int MULC = 4;
    localparam int DIVC = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic       Regfile_weE, Regfile_weM, Regfile_weW, memToRegE, memToRegM;
    logic       branchD, pcSrcD, mdStartD, mdStartE, mdOpE, hiloReadD;
    logic       stallF, stallD, flushD, flushE, forwardAD, forwardBD, mdBusy, mdDone;
    logic [1:0] forwardAE, forwardBE;

    int total = 0;
    int bad   = 0;
    int age   = -1;   // cycles since launch of the op in flight, -1 when idle
    int len   = 0;    // total cycles of the op in flight, launch included

    hazard_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .Regfile_weE(Regfile_weE), .Regfile_weM(Regfile_weM), .Regfile_weW(Regfile_weW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .branchD(branchD), .pcSrcD(pcSrcD),
        .mdStartD(mdStartD), .mdStartE(mdStartE), .mdOpE(mdOpE), .hiloReadD(hiloReadD),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .mdBusy(mdBusy), .mdDone(mdDone)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwdE(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (Regfile_weM && writeRegM == src) return 2'b10;
        if (Regfile_weW && writeRegW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit hitsD(input logic [4:0] r);
        return (r != 5'd0) && (r == rsD || r == rtD);
    endfunction

    task automatic checkAll();
        bit lw, br, md, st, busy, done;
        if (!rst) age = -1;
        busy = (age >= 1);
        done = busy && (age == len - 1);
        lw = memToRegE && hitsD(writeRegE);
        br = branchD && ((Regfile_weE && hitsD(writeRegE)) || (memToRegM && hitsD(writeRegM)));
        md = (hiloReadD || mdStartD) && ((busy && !done) || mdStartE);
        st = rst && (lw || br || md);
        checkVal("stallF", stallF, st);
        checkVal("stallD", stallD, st);
        checkVal("flushE", flushE, st);
        checkVal("flushD", flushD, rst && pcSrcD && !st);
        checkVal("fwdAE", forwardAE, rst ? fwdE(rsE) : 2'b00);
        checkVal("fwdBE", forwardBE, rst ? fwdE(rtE) : 2'b00);
        checkVal("fwdAD", forwardAD, rst && rsD != 5'd0 && Regfile_weM && rsD == writeRegM);
        checkVal("fwdBD", forwardBD, rst && rtD != 5'd0 && Regfile_weM && rtD == writeRegM);
        checkVal("mdBusy", mdBusy, busy);
        checkVal("mdDone", mdDone, done);
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic modelEdge();
        if (!rst) begin
            age = -1;
        end else if (mdStartE && (age < 1 || age == len - 1)) begin
            age = 1;
            len = mdOpE ? DIVC : MULC;
        end else if (age >= 1 && age < len - 1) begin
            age++;
        end else begin
            age = -1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkAll();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        {rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW} = '0;
        {Regfile_weE, Regfile_weM, Regfile_weW, memToRegE, memToRegM} = '0;
        {branchD, pcSrcD, mdStartD, mdStartE, mdOpE, hiloReadD} = '0;
    endtask

    task automatic randInputs();
        rsD = 5'($urandom_range(0, 3));        rtD = 5'($urandom_range(0, 3));
        rsE = 5'($urandom_range(0, 3));        rtE = 5'($urandom_range(0, 3));
        writeRegE = 5'($urandom_range(0, 3));  writeRegM = 5'($urandom_range(0, 3));
        writeRegW = 5'($urandom_range(0, 3));
        Regfile_weE = 1'($urandom);  Regfile_weM = 1'($urandom);  Regfile_weW = 1'($urandom);
        memToRegE = 1'($urandom);    memToRegM = 1'($urandom);
        branchD = 1'($urandom);      pcSrcD = 1'($urandom);
        mdStartD = ($urandom_range(0, 3) == 0);
        hiloReadD = ($urandom_range(0, 3) == 0);
        mdStartE = ($urandom_range(0, 9) == 0);
        mdOpE = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        rst = 1'b0;
        clearInputs();
        @(posedge clk);
        #1;
        // Outputs held low during reset regardless of inputs.
        for (int i = 0; i < 4; i++) begin
            randInputs();
            cycle();
        end
        clearInputs();
        rst = 1'b1;
        cycle();

        // Load-use, then forward from W.
        memToRegE = 1'b1; writeRegE = 5'd8; rsD = 5'd8;
        #1;
        checkVal("lu_stallF", stallF, 1'b1);
        checkVal("lu_flushE", flushE, 1'b1);
        cycle();
        clearInputs();
        rsE = 5'd8; writeRegW = 5'd8; Regfile_weW = 1'b1;
        #1;
        checkVal("lu_clear", stallD, 1'b0);
        checkVal("lu_fwdW", forwardAE, 2'b01);
        cycle();

        // M beats W; register 0 never forwards.
        clearInputs();
        rsE = 5'd5; writeRegM = 5'd5; writeRegW = 5'd5; Regfile_weM = 1'b1; Regfile_weW = 1'b1;
        #1;
        checkVal("prio_M", forwardAE, 2'b10);
        rsE = 5'd0; writeRegM = 5'd0; writeRegW = 5'd0;
        #1;
        checkVal("prio_r0", forwardAE, 2'b00);
        cycle();

        // Branch hazard suppresses the flush; no hazard lets it through.
        clearInputs();
        branchD = 1'b1; rsD = 5'd3; Regfile_weE = 1'b1; writeRegE = 5'd3; pcSrcD = 1'b1;
        #1;
        checkVal("br_stall", stallD, 1'b1);
        checkVal("br_noflush", flushD, 1'b0);
        cycle();
        writeRegE = 5'd4;
        #1;
        checkVal("br_flush", flushD, 1'b1);
        checkVal("br_nostall", stallD, 1'b0);
        cycle();

        // Multiply with a HI/LO reader waiting in D.
        clearInputs();
        mdStartE = 1'b1; hiloReadD = 1'b1;
        #1;
        checkVal("mul_c0_stall", stallD, 1'b1);
        cycle();
        mdStartE = 1'b0;
        for (int c = 1; c < MULC; c++) begin
            #1;
            checkVal("mul_busy", mdBusy, 1'b1);
            checkVal("mul_done", mdDone, c == MULC - 1);
            checkVal("mul_stall", stallD, c < MULC - 1);
            cycle();
        end
        #1;
        checkVal("mul_idle", mdBusy, 1'b0);

        // Back-to-back divides with a second mul/div waiting in D.
        clearInputs();
        mdStartE = 1'b1; mdOpE = 1'b1; mdStartD = 1'b1;
        cycle();
        mdStartE = 1'b0;
        for (int c = 1; c < DIVC - 1; c++) begin
            #1;
            checkVal("div1_done", mdDone, 1'b0);
            checkVal("div1_stall", stallD, 1'b1);
            cycle();
        end
        #1;
        checkVal("div1_done_last", mdDone, 1'b1);
        checkVal("div1_pass", stallD, 1'b0);
        mdStartE = 1'b1;
        #1;
        checkVal("div2_launch_stall", stallD, 1'b1);
        cycle();
        mdStartE = 1'b0; mdStartD = 1'b0;
        for (int c = 1; c < DIVC; c++) begin
            #1;
            checkVal("div2_done", mdDone, c == DIVC - 1);
            cycle();
        end

        // Reset in the middle of a divide aborts it.
        clearInputs();
        mdStartE = 1'b1; mdOpE = 1'b1;
        cycle();
        mdStartE = 1'b0;
        for (int c = 1; c < 5; c++) cycle();
        rst = 1'b0;
        #1;
        checkVal("abort_busy", mdBusy, 1'b0);
        checkVal("abort_done", mdDone, 1'b0);
        cycle();
        rst = 1'b1;
        for (int c = 0; c < DIVC + 8; c++) begin
            #1;
            checkVal("abort_nodone", mdDone, 1'b0);
            cycle();
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            randInputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
